// File: rtl/sequence_generator.sv
// sequence_generator: valid/ready source of the 8-symbol sync pattern, REPEAT frames per start with idle gaps
module sequence_generator #(
  parameter int REPEAT     = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       data_ready,
  output logic [2:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [2:0] SEQ [8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
  localparam logic [7:0] LAST_FRAME = 8'(REPEAT - 1);
  localparam logic [7:0] LAST_GAP   = 8'(GAP_CYCLES - 1);
  state_t     state;
  logic [2:0] idx;
  logic [7:0] frame_cnt;
  logic [7:0] gap_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      frame_cnt  <= 8'd0;
      gap_cnt    <= 8'd0;
      data       <= 3'b000;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        idx        <= 3'd0;
        frame_cnt  <= 8'd0;
        gap_cnt    <= 8'd0;
        data       <= 3'b000;
        data_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= SEND;
            idx        <= 3'd0;
            frame_cnt  <= 8'd0;
            data       <= SEQ[0];
            data_valid <= 1'b1;
            busy       <= 1'b1;
          end
          SEND: if (data_ready) begin
            if (idx != 3'd7) begin
              idx  <= idx + 3'd1;
              data <= SEQ[idx + 3'd1];
            end else if (frame_cnt == LAST_FRAME) begin
              state      <= IDLE;
              idx        <= 3'd0;
              frame_cnt  <= 8'd0;
              data       <= 3'b000;
              data_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              // back-to-back frames: next frame's first symbol follows with no bubble
              idx       <= 3'd0;
              frame_cnt <= frame_cnt + 8'd1;
              data      <= SEQ[0];
            end else begin
              state      <= GAP;
              gap_cnt    <= 8'd0;
              frame_cnt  <= frame_cnt + 8'd1;
              data       <= 3'b000;
              data_valid <= 1'b0;
            end
          end
          GAP: if (gap_cnt == LAST_GAP) begin
            state      <= SEND;
            idx        <= 3'd0;
            gap_cnt    <= 8'd0;
            data       <= SEQ[0];
            data_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: scoreboard bench over three configurations (1x gap2, 3x gap2, 2x gap0)
module tb_sequence_generator;
  localparam int REP [3] = '{1, 3, 2};
  localparam int GAPC [3] = '{2, 2, 0};
  localparam logic [2:0] SEQ [8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
  logic       clock;
  logic       reset;
  logic [2:0] start;
  logic [2:0] abort;
  logic [2:0] ready;
  logic [2:0] data [3];
  logic       valid [3];
  logic       busy [3];
  logic       done [3];
  int          errors = 0;
  int          checks = 0;
  int          busy_cnt [3] = '{default: 0};
  int          done_cnt [3] = '{default: 0};
  logic [31:0] vpat [3] = '{default: 0};
  bit          stall [3] = '{default: 0};
  bit          last_xfer [3] = '{default: 0};
  logic [2:0]  hold_d [3] = '{default: 0};
  int          q [3][$];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sequence_generator #(.REPEAT(REP[g]), .GAP_CYCLES(GAPC[g])) u_dut (
      .clock(clock), .reset(reset), .start(start[g]), .abort(abort[g]), .data_ready(ready[g]),
      .data(data[g]), .data_valid(valid[g]), .busy(busy[g]), .done(done[g])
    );
  end
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic start_burst(input int i);
    start[i] = 1'b1;
    for (int k = 0; k < REP[i] * 8; k++) q[i].push_back(int'(SEQ[k % 8]));
    step();
    start[i] = 1'b0;
    check("start_latency", {busy[i], valid[i], data[i]}, 5'b11001);
  endtask
  task automatic wait_idle(input int i, input int limit);
    for (int n = 0; n < limit && busy[i]; n++) step();
    check("idle_timeout", busy[i], 1'b0);
  endtask
  // monitor: sampled on the falling edge, a valid&ready&!abort here is accepted at the next rising edge
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (busy[i]) begin
        busy_cnt[i]++;
        vpat[i] = {vpat[i][30:0], valid[i]};
        if (!valid[i]) check("gap_data_zero", data[i], 3'b000);
      end
      if (stall[i] && reset) check("hold", {valid[i], data[i]}, {1'b1, hold_d[i]});
      if (done[i]) begin
        done_cnt[i]++;
        check("done_after_last", {last_xfer[i], busy[i], valid[i]}, 3'b100);
      end
      stall[i] = valid[i] && !ready[i] && !abort[i] && reset;
      hold_d[i] = data[i];
      last_xfer[i] = 1'b0;
      if (valid[i] && ready[i] && !abort[i] && reset) begin
        if (q[i].size() == 0) check("xfer_unexpected", 1, 0);
        else begin
          check("symbol", data[i], q[i].pop_front());
          last_xfer[i] = (q[i].size() == 0);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b0, d0;
    reset = 1'b0; start = '0; abort = '0; ready = '1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) check("reset_outputs", {data[i], valid[i], busy[i], done[i]}, 6'd0);
    reset = 1'b1;
    step();
    // single frame, full throughput
    b0 = busy_cnt[0]; d0 = done_cnt[0];
    start_burst(0);
    wait_idle(0, 50);
    check("t1_done_pulse", done[0], 1'b1);
    step();
    check("t1_done_one_cycle", done[0], 1'b0);
    check("t1_busy_cycles", busy_cnt[0] - b0, 8);
    check("t1_done_count", done_cnt[0] - d0, 1);
    // backpressure on idx 3 (symbol 000) for 3 cycles
    start_burst(0);
    repeat (3) step();
    ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold", {valid[0], data[0]}, 4'b1000);
    end
    ready[0] = 1'b1;
    wait_idle(0, 50);
    step();
    // three frames with gaps, stray start mid-burst
    b0 = busy_cnt[1]; d0 = done_cnt[1];
    start_burst(1);
    repeat (5) step();
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    wait_idle(1, 100);
    step();
    check("t3_busy_cycles", busy_cnt[1] - b0, 28);
    check("t3_done_count", done_cnt[1] - d0, 1);
    check("t3_valid_pattern", vpat[1][27:0], {8'hFF, 2'b00, 8'hFF, 2'b00, 8'hFF});
    // two frames back-to-back, then restart in the done cycle
    b0 = busy_cnt[2]; d0 = done_cnt[2];
    start_burst(2);
    wait_idle(2, 100);
    check("t4_done_cycle", done[2], 1'b1);
    check("t4_first_run", vpat[2][15:0], 16'hFFFF);
    start_burst(2);
    wait_idle(2, 100);
    step();
    check("t4_busy_cycles", busy_cnt[2] - b0, 32);
    check("t4_done_count", done_cnt[2] - d0, 2);
    // abort at idx 5
    d0 = done_cnt[1];
    start_burst(1);
    repeat (5) step();
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    q[1].delete();
    check("abort_idle", {valid[1], busy[1], done[1], data[1]}, 6'd0);
    repeat (3) step();
    check("abort_no_done", done_cnt[1] - d0, 0);
    // abort beats start in idle
    start[1] = 1'b1; abort[1] = 1'b1;
    step();
    start[1] = 1'b0; abort[1] = 1'b0;
    check("abort_start_idle", {valid[1], busy[1]}, 2'b00);
    step();
    // async reset in the middle of a gap
    start_burst(1);
    repeat (8) step();
    check("in_gap", {busy[1], valid[1]}, 2'b10);
    #2 reset = 1'b0;
    #1 check("async_reset", {data[1], valid[1], busy[1], done[1]}, 6'd0);
    q[1].delete();
    step();
    reset = 1'b1;
    repeat (3) step();
    check("post_reset_idle", busy[1], 1'b0);
    b0 = busy_cnt[1]; d0 = done_cnt[1];
    start_burst(1);
    wait_idle(1, 100);
    step();
    check("t6_busy_cycles", busy_cnt[1] - b0, 28);
    check("t6_done_count", done_cnt[1] - d0, 1);
    check("t6_valid_pattern", vpat[1][27:0], {8'hFF, 2'b00, 8'hFF, 2'b00, 8'hFF});
    for (int i = 0; i < 3; i++) check("queue_drained", q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Transmit-side source for the fixed 8-symbol, 3-bit sync pattern 001,101,110,000,110,110,011,101. The receive-side detector watches for this same pattern.
- Emits the pattern on a valid/ready stream, REPEAT times per start request, with a programmable idle gap between frames.
- Sits in the stimulus/link path, upstream of the receive-side detector.

Parameters:
- REPEAT, 1, frames sent per accepted start; legal range 1..255.
- GAP_CYCLES, 2, idle cycles with data_valid=0 between consecutive frames of one burst; legal range 0..255.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces all state and outputs to reset values immediately.
- start  input  1  request a burst; sampled only in IDLE.
- abort  input  1  synchronous cancel; takes priority over start and over every state.
- data_ready  input  1  downstream accepts the current symbol when data_valid=1 and data_ready=1 at a rising edge.
- data  output  3  current symbol; 3'b000 whenever data_valid=0.
- data_valid  output  1  data holds a valid symbol.
- busy  output  1  high in SEND and GAP states.
- done  output  1  one-cycle pulse after the last symbol of the burst is accepted.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, idx=0, frame_cnt=0, gap_cnt=0, data=000, data_valid=0, busy=0, done=0.
- Symbol ROM, SEQ[0..7] = 001,101,110,000,110,110,011,101.
- IDLE:
  - start=1 and abort=0 at edge N -> state SEND, idx=0, frame_cnt=0.
  - Right after edge N: data=001, data_valid=1, busy=1. Latency is one edge.
- SEND:
  - data=SEQ[idx], data_valid=1.
  - Transfer occurs on an edge with data_ready=1; then idx increments.
  - data_ready=0: data, data_valid and idx hold unchanged for as many cycles as needed. data must not change while valid and not accepted.
  - Transfer of idx=7 with frame_cnt=REPEAT-1 -> IDLE, data_valid=0, data=000, busy=0, done=1 for exactly one cycle.
  - Transfer of idx=7 with frame_cnt<REPEAT-1 and GAP_CYCLES=0 -> stay in SEND, idx=0, frame_cnt+1. Back-to-back frames, no bubble.
  - Transfer of idx=7 with frame_cnt<REPEAT-1 and GAP_CYCLES>0 -> GAP, gap_cnt=0, frame_cnt+1.
- GAP:
  - data_valid=0, data=000, busy=1.
  - gap_cnt increments each cycle.
  - When gap_cnt=GAP_CYCLES-1 -> SEND, idx=0. Exactly GAP_CYCLES cycles of data_valid=0.
  - data_ready is ignored.
- With data_ready held high, one frame occupies exactly 8 consecutive valid cycles.
- A burst lasts REPEAT*8 + (REPEAT-1)*GAP_CYCLES cycles of busy=1.
- Boundary conditions:
  - start while busy=1: ignored, not queued.
  - start in the cycle done=1 (state is IDLE): accepted; the new burst begins next edge.
  - abort=1 in SEND or GAP: next edge -> IDLE with reset values. No done pulse. A partially sent frame is dropped even mid-transfer; an acceptance on that same edge does not count.
  - abort=1 with start=1 in IDLE: stay in IDLE.
  - reset asserted mid-burst: outputs return to reset values asynchronously. After release, the block waits for a new start.
- Counter widths:
  - idx is 3 bits and wraps 7->0 only via the frame-end rules above.
  - frame_cnt and gap_cnt are 8 bits.

Test Plan:
- Reset release, REPEAT=1, data_ready=1, start pulse at edge 0 -> edges 1..8 show 001,101,110,000,110,110,011,101 with valid=1; done=1 in the cycle after the last symbol; busy low afterwards.
- Backpressure: data_ready low for 3 cycles during symbol idx=3 -> data stays 000 with valid=1 for 4 cycles; sequence resumes 110,110,011,101 unchanged.
- REPEAT=3, GAP_CYCLES=2, data_ready=1 -> 8 valid, 2 invalid, 8 valid, 2 invalid, 8 valid; single done pulse; busy high for 28 cycles.
- REPEAT=2, GAP_CYCLES=0 -> 16 consecutive valid symbols; the 9th is 001; one done pulse.
- abort at idx=5 -> next cycle valid=0, busy=0, done stays 0; a start pulse while busy=1 in an earlier burst is ignored.
- Async reset asserted mid-GAP, then a new start -> outputs zero immediately; the new burst starts cleanly at symbol 001 with frame_cnt=0.
